// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;

    localparam int INSTR_W   = 19;
    localparam int BYTE_W    = 8;
    localparam int HDR_BYTES = 2;
    localparam int CSUM_W    = 8;
    localparam int B0_BITS   = INSTR_W - 2 * BYTE_W;

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        W0     = 3'd2,
        W1     = 3'd3,
        W2     = 3'd4,
        CSUM   = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } loader_state_t;

    function automatic logic [CSUM_W-1:0] csum_step(
        input logic [CSUM_W-1:0] acc,
        input logic [BYTE_W-1:0] data
    );
        return acc ^ data;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Loads a framed big-endian byte stream into instruction memory, checks the
// XOR checksum and releases the CPU from reset on success.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [BYTE_W-1:0]    in_data,
    output logic                 in_ready,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [INSTR_W-1:0]   wr_data,
    output logic                 cpu_rst_n,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_W:0]      word_count
);

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    loader_state_t r_state;
    loader_state_t w_state_nxt;

    logic                r_in_ready;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [INSTR_W-1:0]  r_wr_data;
    logic                r_cpu_rst_n;
    logic                r_done;
    logic                r_error;
    logic [ADDR_W:0]     r_word_count;
    logic [ADDR_W:0]     r_words_left;
    logic [CSUM_W-1:0]   r_csum;
    logic [BYTE_W-1:0]   r_hdr_hi;
    logic [B0_BITS-1:0]  r_b0;
    logic [BYTE_W-1:0]   r_b1;

    logic                w_xfer;
    logic [2*BYTE_W-1:0] w_hdr_n;
    logic                w_hdr_too_big;
    logic                w_hdr_empty;
    logic                w_b0_bad;
    logic                w_last_word;
    logic                w_csum_ok;

    assign w_xfer        = in_valid & r_in_ready;
    assign w_hdr_n       = {r_hdr_hi, in_data};
    assign w_hdr_too_big = (32'(w_hdr_n) > DEPTH);
    assign w_hdr_empty   = (w_hdr_n == 16'd0);
    // Instruction words carry only 3 significant bits in their first byte.
    assign w_b0_bad      = |in_data[BYTE_W-1:B0_BITS];
    assign w_last_word   = (r_words_left == (ADDR_W+1)'(1));
    assign w_csum_ok     = (in_data == r_csum);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= HDR_HI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; every state advances only on an accepted byte.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HDR_HI: begin
                if (w_xfer) w_state_nxt = HDR_LO;
                else        w_state_nxt = r_state;
            end
            HDR_LO: begin
                if (!w_xfer)           w_state_nxt = r_state;
                else if (w_hdr_too_big) w_state_nxt = ERR;
                else if (w_hdr_empty)   w_state_nxt = CSUM;
                else                    w_state_nxt = W0;
            end
            W0: begin
                if (!w_xfer)      w_state_nxt = r_state;
                else if (w_b0_bad) w_state_nxt = ERR;
                else               w_state_nxt = W1;
            end
            W1: begin
                if (w_xfer) w_state_nxt = W2;
                else        w_state_nxt = r_state;
            end
            W2: begin
                if (!w_xfer)         w_state_nxt = r_state;
                else if (w_last_word) w_state_nxt = CSUM;
                else                  w_state_nxt = W0;
            end
            CSUM: begin
                if (!w_xfer)       w_state_nxt = r_state;
                else if (w_csum_ok) w_state_nxt = DONE;
                else                w_state_nxt = ERR;
            end
            DONE:    w_state_nxt = DONE;
            ERR:     w_state_nxt = ERR;
            default: w_state_nxt = ERR;
        endcase
    end

    // Datapath: status flags, checksum, word assembly and memory write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_in_ready   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= ADDR_W'(BASE_ADDR);
            r_wr_data    <= {INSTR_W{1'b0}};
            r_cpu_rst_n  <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= {(ADDR_W+1){1'b0}};
            r_words_left <= {(ADDR_W+1){1'b0}};
            r_csum       <= {CSUM_W{1'b0}};
            r_hdr_hi     <= {BYTE_W{1'b0}};
            r_b0         <= {B0_BITS{1'b0}};
            r_b1         <= {BYTE_W{1'b0}};
        end else begin
            r_in_ready  <= (w_state_nxt != DONE) && (w_state_nxt != ERR);
            r_done      <= (w_state_nxt == DONE);
            r_cpu_rst_n <= (w_state_nxt == DONE);
            r_error     <= (w_state_nxt == ERR);
            r_wr_en     <= 1'b0;
            // Address advances the cycle after each write strobe.
            if (r_wr_en) begin
                r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
            if (w_xfer) begin
                if (r_state != CSUM) begin
                    r_csum <= csum_step(r_csum, in_data);
                end
                case (r_state)
                    HDR_HI: r_hdr_hi     <= in_data;
                    HDR_LO: r_words_left <= (ADDR_W+1)'(w_hdr_n);
                    W0:     r_b0         <= in_data[B0_BITS-1:0];
                    W1:     r_b1         <= in_data;
                    W2: begin
                        r_wr_en      <= 1'b1;
                        r_wr_data    <= {r_b0, r_b1, in_data};
                        r_word_count <= r_word_count + (ADDR_W+1)'(1);
                        r_words_left <= r_words_left - (ADDR_W+1)'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign cpu_rst_n  = r_cpu_rst_n;
    assign done       = r_done;
    assign error      = r_error;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed-vector bench for imem_loader: frames, checksum, errors, gaps, reset.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic [7:0]          in_data = 8'h00;
    logic                in_ready;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [18:0]         wr_data;
    logic                cpu_rst_n;
    logic                done;
    logic                error;
    logic [ADDR_W:0]     word_count;

    int errors = 0;
    int checks = 0;

    logic [7:0]  frm[$];
    logic [31:0] mon_addr[$];
    logic [31:0] mon_data[$];

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Records every memory write strobe seen between clock edges.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            mon_addr.push_back(32'(wr_addr));
            mon_data.push_back(32'(wr_data));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_addr.delete();
        mon_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            chk("ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int gap);
        foreach (frm[i]) send_byte(frm[i], gap);
    endtask

    task automatic chk_two_writes(input string tag);
        chk({tag, "_nwr"}, 32'(mon_addr.size()), 32'd2);
        if (mon_addr.size() == 2) begin
            chk({tag, "_a0"}, mon_addr[0], 32'd0);
            chk({tag, "_d0"}, mon_data[0], 32'h00001);
            chk({tag, "_a1"}, mon_addr[1], 32'd1);
            chk({tag, "_d1"}, mon_data[1], 32'h7FFFF);
        end
    endtask

    initial begin
        // 1: normal load, reset values, per-word write timing
        do_reset();
        chk("rst_in_ready",   32'(in_ready),   32'd0);
        chk("rst_wr_en",      32'(wr_en),      32'd0);
        chk("rst_wr_addr",    32'(wr_addr),    32'd0);
        chk("rst_wr_data",    32'(wr_data),    32'd0);
        chk("rst_cpu_rst_n",  32'(cpu_rst_n),  32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_error",      32'(error),      32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);

        frm = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h01};
        send_frame(0);
        chk("t1_wr0_en",   32'(wr_en),      32'd1);
        chk("t1_wr0_addr", 32'(wr_addr),    32'd0);
        chk("t1_wr0_data", 32'(wr_data),    32'h00001);
        chk("t1_wc1",      32'(word_count), 32'd1);
        frm = '{8'h07, 8'hFF, 8'hFF};
        send_frame(0);
        chk("t1_wr1_en",   32'(wr_en),      32'd1);
        chk("t1_wr1_addr", 32'(wr_addr),    32'd1);
        chk("t1_wr1_data", 32'(wr_data),    32'h7FFFF);
        chk("t1_wc2",      32'(word_count), 32'd2);
        chk("t1_done_pre", 32'(done),       32'd0);
        send_byte(8'h04, 0);
        chk("t1_done",      32'(done),      32'd1);
        chk("t1_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        chk("t1_in_ready",  32'(in_ready),  32'd0);
        chk("t1_error",     32'(error),     32'd0);
        chk("t1_wr_addr",   32'(wr_addr),   32'd2);
        repeat (4) @(posedge clk);
        #1;
        chk("t1_done_hold", 32'(done),      32'd1);
        chk_two_writes("t1");

        // 2: bad checksum
        do_reset();
        frm = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h07, 8'hFF, 8'hFF, 8'h05};
        send_frame(0);
        chk("t2_error",     32'(error),     32'd1);
        chk("t2_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("t2_done",      32'(done),      32'd0);
        chk("t2_in_ready",  32'(in_ready),  32'd0);
        chk_two_writes("t2");

        // 3a: oversize header
        do_reset();
        frm = '{8'h01, 8'h01};
        send_frame(0);
        chk("t3a_error",    32'(error),     32'd1);
        chk("t3a_in_ready", 32'(in_ready),  32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t3a_nwr",      32'(mon_addr.size()), 32'd0);

        // 3b: N == DEPTH is still legal
        do_reset();
        frm = '{8'h01, 8'h00};
        send_frame(0);
        chk("t3b_error",    32'(error),     32'd0);
        chk("t3b_in_ready", 32'(in_ready),  32'd1);

        // 3c: illegal first word byte
        do_reset();
        frm = '{8'h00, 8'h01, 8'h08};
        send_frame(0);
        chk("t3c_error",    32'(error),     32'd1);
        chk("t3c_in_ready", 32'(in_ready),  32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t3c_nwr",      32'(mon_addr.size()), 32'd0);
        chk("t3c_wc",       32'(word_count), 32'd0);

        // 4: empty program
        do_reset();
        frm = '{8'h00, 8'h00, 8'h00};
        send_frame(0);
        chk("t4_done",      32'(done),       32'd1);
        chk("t4_cpu_rst_n", 32'(cpu_rst_n),  32'd1);
        chk("t4_wc",        32'(word_count), 32'd0);
        chk("t4_nwr",       32'(mon_addr.size()), 32'd0);

        // 5: gaps between bytes
        do_reset();
        frm = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h07, 8'hFF, 8'hFF, 8'h04};
        send_frame(2);
        chk("t5_done",      32'(done),       32'd1);
        chk("t5_error",     32'(error),      32'd0);
        chk("t5_wc",        32'(word_count), 32'd2);
        chk_two_writes("t5");

        // 6: reset while in W1 of word 1, then a fresh one-word frame
        do_reset();
        frm = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h07};
        send_frame(0);
        do_reset();
        chk("t6_rst_wc",        32'(word_count), 32'd0);
        chk("t6_rst_cpu_rst_n", 32'(cpu_rst_n),  32'd0);
        chk("t6_rst_wr_addr",   32'(wr_addr),    32'd0);
        // checksum 00^01^02^34^56 = 61
        frm = '{8'h00, 8'h01, 8'h02, 8'h34, 8'h56, 8'h61};
        send_frame(0);
        chk("t6_done", 32'(done),       32'd1);
        chk("t6_wc",   32'(word_count), 32'd1);
        chk("t6_nwr",  32'(mon_addr.size()), 32'd1);
        if (mon_addr.size() == 1) begin
            chk("t6_a0", mon_addr[0], 32'd0);
            chk("t6_d0", mon_data[0], 32'h23456);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream program loader that fills the 19-bit CPU's instruction memory before execution. It writes the words the CPU later fetches by PC. It holds the CPU in reset and accepts a framed byte stream over a valid/ready handshake. It assembles 19-bit instruction words, writes them to consecutive instruction-memory addresses, verifies an XOR checksum, then releases the CPU.

Parameters:
ADDR_W, 8, instruction-memory address width; DEPTH = 2**ADDR_W words
BASE_ADDR, 0, first instruction-memory address written
INSTR_W, 19, instruction word width (fixed; not to be overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
in_valid  in  1  in_data holds a valid byte
in_data  in  8  stream byte
in_ready  out  1  loader accepts a byte this cycle (transfer = in_valid & in_ready)
wr_en  out  1  instruction-memory write strobe, one cycle per word
wr_addr  out  ADDR_W  instruction-memory write address
wr_data  out  19  instruction word to write
cpu_rst_n  out  1  CPU reset (active-low); 0 while loading
done  out  1  load completed, checksum good
error  out  1  load aborted
word_count  out  ADDR_W+1  words written so far

Behaviour:
- Reset (rst=0 at posedge):
  - state HDR_HI, in_ready=0 for that cycle.
  - wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_rst_n=0, done=0, error=0, word_count=0, checksum=0.
  - Instruction-memory contents are not cleared.
- Frame format, big-endian:
  - 2-byte header N = word count.
  - N words of 3 bytes each.
  - 1 checksum byte = XOR of all preceding frame bytes (header included).
- States and transitions:
  - HDR_HI -> HDR_LO -> (N==0 ? CSUM : W0).
  - W0 -> W1 -> W2 -> (last word ? CSUM : W0).
  - CSUM -> DONE or ERR.
  - DONE and ERR are terminal until reset.
- Each state advances only on a transfer. Gaps in in_valid stall with no side effects.
- in_ready=1 in HDR_HI..CSUM; 0 in DONE and ERR.
- Header check: after HDR_LO, N > DEPTH -> ERR immediately. No writes occur.
- W0 byte check: bits [7:3] must be 0; otherwise ERR on that transfer. The word is not written.
- Word assembly and write:
  - wr_data = {b0[2:0], b1, b2}.
  - wr_en pulses high exactly one cycle after the W2 transfer, with wr_addr = BASE_ADDR + index.
  - word_count increments in that same cycle.
  - wr_addr increments the cycle after the write. It wraps modulo DEPTH, though the N check prevents wrap in practice.
- Checksum: accumulated over every accepted byte except the checksum byte itself. Match -> DONE, else ERR.
- DONE:
  - done=1 and cpu_rst_n=1 from the cycle after the CSUM transfer.
  - Both hold until reset.
- ERR:
  - error=1 from the cycle after the offending transfer.
  - cpu_rst_n stays 0; done=0; no further writes.
- Simultaneous events: a transfer arriving in the same cycle as the W2 write pulse is a normal W0 accept. Back-to-back words at full rate yield one write every 3 cycles.
- Reset mid-operation: rst=0 in any state returns to HDR_HI with all reset values. A partial word is discarded. Words already written stay in memory, but word_count returns to 0.
- All outputs registered. Latency from final checksum byte to cpu_rst_n=1 is 1 cycle.

Decomposition:
- Shared package holds:
  - INSTR_W=19
  - loader state enum (HDR_HI, HDR_LO, W0, W1, W2, CSUM, DONE, ERR)
  - header/checksum byte-width constants
- Memory write port signals match the existing Instruction_Memory write side. No separate memory is instantiated here.
- No sub-module is required. The checksum accumulator and word assembler stay inline in imem_loader.

Test Plan:
1. Normal load: bytes 00 02 00 00 01 07 FF FF 04 with in_valid held high -> wr_en at addr 0 data 0x00001, then addr 1 data 0x7FFFF. word_count=2. done=1 and cpu_rst_n=1 one cycle after byte 04.
2. Bad checksum: same frame, last byte 05 -> both words written, then error=1, cpu_rst_n=0, done=0, in_ready=0.
3. Oversize / illegal data:
   - Header 01 01 (257 > DEPTH 256) -> error=1 after second byte, no wr_en.
   - Separate run: frame 00 01 08 ... -> error on the 0x08 byte, no write.
4. Empty program: 00 00 00 -> no wr_en, word_count=0, done=1.
5. Backpressure/gaps: frame from test 1 with in_valid toggling 1,0,0,1... -> identical writes and final state. No double-accept of a byte.
6. Reset mid-load: rst=0 for one cycle while in W1 of word 1, then a fresh frame 00 01 12 34 56 (checksum 00^01^12^34^56=71) followed by 71 -> after reset word_count=0 and cpu_rst_n=0. The fresh frame writes addr 0 with 0x23456 (b0[2:0]=2), then done=1.
